// File: rtl/spike_aer_encoder_if.sv
// Address-event stream between the spike encoder and its consumer.
// An event transfers on a rising clk edge when ev_valid && ev_ready. Once ev_valid is high,
// it stays high and ev_id/ev_time/ev_last hold steady until that transfer. ev_ready may
// change freely, and the master never looks at ev_ready when it decides ev_valid.
interface spike_aer_encoder_if #(
  parameter int ID_W = 7,
  parameter int TS_W = 16
) ();
  logic            ev_valid;
  logic            ev_ready;
  logic [ID_W-1:0] ev_id;
  logic [TS_W-1:0] ev_time;
  logic            ev_last;

  modport master (output ev_valid, ev_id, ev_time, ev_last, input ev_ready);
  modport slave  (input ev_valid, ev_id, ev_time, ev_last, output ev_ready);
endinterface

// File: rtl/spike_aer_encoder.sv
// Captures one population spike vector per sweep and turns its set bits into an AER stream.
// Events leave lowest neuron first. A strobe that arrives while a frame is still draining is dropped and counted.
module spike_aer_encoder #(
  parameter int N_NEURONS = 128,
  parameter int ID_W      = 7,
  parameter int TS_W      = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_NEURONS-1:0]   population,
  input  logic                   pop_valid,
  spike_aer_encoder_if.master    ev,
  output logic                   frame_done,
  output logic [ID_W:0]          frame_spikes,
  output logic [15:0]            overrun_cnt,
  output logic                   dbg_state
);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  localparam logic [N_NEURONS-1:0] ONE_N = N_NEURONS'(1);

  state_t                 state_q, state_d;
  logic [N_NEURONS-1:0]   frame;
  logic [TS_W-1:0]        ts_cnt;
  logic [TS_W-1:0]        cur_ts;

  logic [ID_W-1:0]        low_id;
  logic [N_NEURONS-1:0]   low_mask;
  logic                   single_bit;
  logic                   pop_nonzero;
  logic                   handshake;
  logic                   last_hs;
  logic                   accept;
  logic                   drop;

  function automatic logic [ID_W:0] popcount(input logic [N_NEURONS-1:0] v);
    logic [ID_W:0] c;
    c = '0;
    for (int i = 0; i < N_NEURONS; i++) c = c + {{ID_W{1'b0}}, v[i]};
    return c;
  endfunction

  // The loop goes from the top bit down, so the lowest set bit is the last one written and wins.
  always_comb begin
    low_id = '0;
    for (int i = N_NEURONS - 1; i >= 0; i--) begin
      if (frame[i]) low_id = ID_W'(i);
    end
  end

  assign low_mask    = ONE_N << low_id;
  assign single_bit  = (frame != '0) && ((frame & (frame - ONE_N)) == '0);
  assign pop_nonzero = (population != '0);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    ev.ev_valid = 1'b0;
    ev.ev_id    = '0;
    ev.ev_time  = '0;
    ev.ev_last  = 1'b0;
    handshake   = 1'b0;
    last_hs     = 1'b0;
    accept      = 1'b0;
    drop        = 1'b0;
    case (state_q)
      IDLE: begin
        accept = pop_valid;
        if (pop_valid && pop_nonzero) state_d = SCAN;
      end
      SCAN: begin
        ev.ev_valid = 1'b1;
        ev.ev_id    = low_id;
        ev.ev_time  = cur_ts;
        ev.ev_last  = single_bit;
        handshake   = ev.ev_ready;
        last_hs     = ev.ev_ready && single_bit;
        // A strobe that lands on the final handshake starts the next frame directly.
        accept      = pop_valid && last_hs;
        drop        = pop_valid && !last_hs;
        if (last_hs) state_d = (pop_valid && pop_nonzero) ? SCAN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame        <= '0;
      ts_cnt       <= '0;
      cur_ts       <= '0;
      frame_done   <= 1'b0;
      frame_spikes <= '0;
      overrun_cnt  <= '0;
    end else begin
      frame_done <= last_hs || (accept && !pop_nonzero);
      if (pop_valid) ts_cnt <= ts_cnt + 1'b1;
      if (accept) begin
        frame        <= population;
        cur_ts       <= ts_cnt;
        frame_spikes <= popcount(population);
      end else if (handshake) begin
        frame <= frame & ~low_mask;
      end
      if (drop && (overrun_cnt != 16'hFFFF)) overrun_cnt <= overrun_cnt + 16'd1;
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Bench for spike_aer_encoder. A queue-based reference model predicts every event, frame_done
// pulse and counter value, under directed scenarios followed by random traffic.
module tb_spike_aer_encoder;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] population;
  logic         pop_valid;
  logic         frame_done;
  logic [7:0]   frame_spikes;
  logic [15:0]  overrun_cnt;
  logic         dbg_state;

  spike_aer_encoder_if #(.ID_W(7), .TS_W(16)) ev ();

  spike_aer_encoder dut (
    .clk          (clk),
    .reset        (reset),
    .population   (population),
    .pop_valid    (pop_valid),
    .ev           (ev),
    .frame_done   (frame_done),
    .frame_spikes (frame_spikes),
    .overrun_cnt  (overrun_cnt),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state: the ids of the current frame that have not been sent yet, in order.
  int          m_pend[$];
  logic [15:0] m_ts_cnt = '0;
  logic [15:0] m_cur_ts = '0;
  logic [15:0] m_ovr    = '0;
  logic [7:0]  m_spk    = '0;
  logic        m_done   = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic busy;
    busy = (m_pend.size() > 0);
    check_val("ev_valid", 32'(ev.ev_valid), 32'(busy));
    check_val("dbg_state", 32'(dbg_state), 32'(busy));
    if (busy) begin
      check_val("ev_id", 32'(ev.ev_id), 32'(m_pend[0]));
      check_val("ev_time", 32'(ev.ev_time), 32'(m_cur_ts));
      check_val("ev_last", 32'(ev.ev_last), 32'(m_pend.size() == 1));
    end
    check_val("frame_done", 32'(frame_done), 32'(m_done));
    check_val("frame_spikes", 32'(frame_spikes), 32'(m_spk));
    check_val("overrun_cnt", 32'(overrun_cnt), 32'(m_ovr));
  endtask

  task automatic model_update(input logic pv, input logic [127:0] pop, input logic rdy,
                              input logic rst);
    logic done_n;
    if (rst) begin
      m_pend.delete();
      m_ts_cnt = '0;
      m_cur_ts = '0;
      m_ovr    = '0;
      m_spk    = '0;
      m_done   = 1'b0;
      return;
    end
    done_n = 1'b0;
    if (rdy && m_pend.size() > 0) begin
      void'(m_pend.pop_front());
      if (m_pend.size() == 0) done_n = 1'b1;
    end
    if (pv) begin
      if (m_pend.size() == 0) begin
        for (int i = 0; i < 128; i++) if (pop[i]) m_pend.push_back(i);
        m_cur_ts = m_ts_cnt;
        m_spk    = 8'(m_pend.size());
        if (m_pend.size() == 0) done_n = 1'b1;
      end else if (m_ovr != 16'hFFFF) begin
        m_ovr = m_ovr + 16'd1;
      end
      m_ts_cnt = m_ts_cnt + 16'd1;
    end
    m_done = done_n;
  endtask

  // Called at a negedge: check the outputs, drive the inputs for the next posedge, advance the model.
  task automatic cycle(input logic pv, input logic [127:0] pop, input logic rdy, input logic rst);
    check_outputs();
    pop_valid   = pv;
    population  = pop;
    ev.ev_ready = rdy;
    reset       = rst;
    model_update(pv, pop, rdy, rst);
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [127:0] rand_sparse();
    logic [127:0] a, b;
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    return a & b & {$urandom, $urandom, $urandom, $urandom};
  endfunction

  logic [127:0] v3;
  logic [127:0] v7;
  logic [127:0] ones;
  int           ready_pat[4] = '{1, 0, 0, 1};
  int           guard;

  initial begin
    reset       = 1'b1;
    pop_valid   = 1'b0;
    population  = '0;
    ev.ev_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Single frame with bits 3, 64 and 127, consumer always ready.
    v3 = '0;
    v3[3] = 1'b1; v3[64] = 1'b1; v3[127] = 1'b1;
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, v3, 1'b1, 1'b0);
    repeat (4) cycle(1'b0, '0, 1'b1, 1'b0);
    check_val("spikes_3", 32'(frame_spikes), 32'd3);

    // The same frame again, with backpressure.
    cycle(1'b1, v3, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) cycle(1'b0, '0, 1'(ready_pat[i % 4]), 1'b0);

    // An empty frame, which only produces a frame_done pulse.
    cycle(1'b1, '0, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);

    // Overrun while a full frame is stalled, then a strobe that lands on the final handshake.
    cycle(1'b0, '0, 1'b0, 1'b1);
    ones = '1;
    cycle(1'b1, ones, 1'b0, 1'b0);
    repeat (9) cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, rand_sparse(), 1'b0, 1'b0);
    repeat (3) cycle(1'b0, '0, 1'b0, 1'b0);
    check_val("overrun_one", 32'(overrun_cnt), 32'd1);
    guard = 0;
    while (m_pend.size() > 1 && guard < 300) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      guard++;
    end
    check_val("drain_bound", 32'(m_pend.size()), 32'd1);
    cycle(1'b1, v3, 1'b1, 1'b0);
    check_val("overrun_hold", 32'(overrun_cnt), 32'd1);
    repeat (5) cycle(1'b0, '0, 1'b1, 1'b0);

    // Reset while 5 events of a 7-spike frame are still pending. pop_valid is high on the reset edge too.
    v7 = '0;
    for (int i = 0; i < 7; i++) v7[i * 17] = 1'b1;
    cycle(1'b1, v7, 1'b1, 1'b0);
    repeat (2) cycle(1'b0, '0, 1'b1, 1'b0);
    check_val("pending_5", 32'(m_pend.size()), 32'd5);
    cycle(1'b1, v3, 1'b1, 1'b1);
    check_val("rst_ev_valid", 32'(ev.ev_valid), 32'd0);
    check_val("rst_ev_id", 32'(ev.ev_id), 32'd0);
    check_val("rst_ev_time", 32'(ev.ev_time), 32'd0);
    check_val("rst_ev_last", 32'(ev.ev_last), 32'd0);
    cycle(1'b1, v7, 1'b0, 1'b0);
    check_val("post_rst_time", 32'(ev.ev_time), 32'd0);
    repeat (8) cycle(1'b0, '0, 1'b1, 1'b0);

    // Timestamp wrap and overrun saturation: 65535 dropped strobes bring ts_cnt back to 0.
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b1, v3, 1'b0, 1'b0);
    for (int i = 0; i < 65535; i++) cycle(1'b1, '0, 1'b0, 1'b0);
    check_val("ovr_sat", 32'(overrun_cnt), 32'hFFFF);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, v7, 1'b1, 1'b0);
    check_val("wrap_time", 32'(ev.ev_time), 32'd0);
    repeat (4) cycle(1'b1, '0, 1'b0, 1'b0);
    check_val("ovr_stay_sat", 32'(overrun_cnt), 32'hFFFF);
    repeat (10) cycle(1'b0, '0, 1'b1, 1'b0);

    // Random traffic.
    cycle(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 2000; i++) begin
      logic         pv;
      logic [127:0] p;
      pv = ($urandom_range(0, 15) == 0);
      p  = ($urandom_range(0, 7) == 0) ? '0 : rand_sparse();
      cycle(pv, p, 1'($urandom_range(0, 3) != 0), 1'b0);
    end
    repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/spike_aer_encoder.md
# spike_aer_encoder

Downstream consumer of the time-multiplexed Izhikevich population core. Once per neuron sweep it captures the 128-bit population spike vector and serialises every set bit into an address-event (AER) stream of {frame timestamp, neuron id}, one event per handshake. The stream feeds the spike FIFO / host readout. Frames that arrive while the previous frame is still draining are counted and dropped.

## Interface
- N_NEURONS, 128, width of population vector
- ID_W, 7, neuron id width (log2 N_NEURONS)
- TS_W, 16, frame timestamp width
- clk  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high
- population  in  N_NEURONS  spike vector for one sweep; bit i = neuron i fired
- pop_valid  in  1  one-cycle strobe: population holds a new sweep
- ev_valid  out  1  event available
- ev_ready  in  1  consumer accepts event when ev_valid && ev_ready
- ev_id  out  ID_W  neuron index of current event
- ev_time  out  TS_W  timestamp of the frame the event belongs to
- ev_last  out  1  current event is the last one of its frame
- frame_done  out  1  one-cycle pulse when a frame finishes draining (including empty frames)
- frame_spikes  out  ID_W+1  popcount of the most recently accepted frame
- overrun_cnt  out  16  saturating count of dropped frames

## Operation
- Registers: frame (N_NEURONS), ts_cnt (TS_W), cur_ts (TS_W), state {IDLE, SCAN}.
- ts_cnt increments (wraps mod 2^TS_W) on every pop_valid, accepted or dropped.
- IDLE, pop_valid: frame <= population, cur_ts <= ts_cnt, frame_spikes <= popcount(population).
  - population nonzero: go to SCAN.
  - population zero: stay in IDLE, pulse frame_done next cycle.
- SCAN: ev_valid = 1.
  - ev_id = index of lowest set bit of frame.
  - ev_time = cur_ts.
  - ev_last = (exactly one bit set).
- SCAN, handshake: clear that bit of frame. If it was the last bit, go to IDLE and pulse frame_done.
- SCAN, no handshake: ev_id, ev_time and ev_last hold stable. ev_valid never deasserts without a handshake.
- SCAN, pop_valid without last-event handshake: frame is dropped. overrun_cnt increments, saturating at 16'hFFFF. Current frame is unaffected.
- Same cycle pop_valid and last-event handshake: the new frame is accepted exactly as in IDLE, with no drop. state goes to SCAN if the new vector is nonzero, otherwise IDLE.
- Reset in any state:
  - state=IDLE, frame=0, ts_cnt=0, cur_ts=0.
  - outputs zero: ev_valid, ev_id, ev_time, ev_last, frame_done, frame_spikes, overrun_cnt.
  - Any partially drained frame is discarded.
- Reset has priority over pop_valid.

## Timing
- pop_valid at edge t → ev_valid high after edge t (the cycle t+1 view). First event is visible 1 cycle after the strobe.
- Throughput: 1 event/cycle while ev_ready is held high. A k-spike frame drains in k cycles.
- frame_done is high in the cycle after the final handshake, or the cycle after an empty-frame strobe.
- ev_id/ev_time/ev_last: combinational from registered frame/cur_ts. No combinational path from ev_ready or population to outputs.
- Upstream sweep is 256 clk for 128 neurons, so a full 128-spike frame drains without overrun when ev_ready=1.

## Test plan
- Single frame population=bits {3,64,127}, pop_valid, ev_ready=1 → events id 3, 64, 127 on consecutive cycles with ev_time=0, ev_last only on 127, frame_done next cycle, frame_spikes=3.
- Backpressure: same frame, ev_ready toggling 1,0,0,1,… → each id held stable while ready=0, no loss or duplication, order preserved.
- Empty frame population=0 → no ev_valid, frame_done pulses 1 cycle later, ts_cnt advances to 1.
- Overrun: frame of 128 ones, ev_ready=0, second pop_valid 10 cycles later → overrun_cnt=1, next ev_time of the drained frame unchanged. A third strobe landing in the same cycle as the last handshake is accepted, and overrun_cnt stays 1.
- Wrap/saturation: 65537 strobes with empty frames → ev_time wraps to 0 at frame 65536. Forced overruns saturate overrun_cnt at 16'hFFFF.
- Reset asserted mid-SCAN with 5 events pending → next cycle ev_valid=0, all outputs zero. A subsequent frame starts at ev_time=0.
